// File: rtl/mem_wb.sv
// MEM/WB stage of the 3-stage core: data BRAM and MMIO access, load alignment,
// writeback selection and the forwarding source for EX.
module mem_wb #(
  parameter int unsigned DMEM_AWIDTH = 14,
  parameter logic [3:0]  IO_NIBBLE   = 4'h8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid_i,
  input  logic [31:0]            ex_alu_result_i,
  input  logic [31:0]            ex_mem_write_i,
  input  logic [4:0]             ex_wb_addr_i,
  input  logic [1:0]             ex_wr_mux_i,
  input  logic [31:0]            ex_pc_plus_i,
  input  logic [2:0]             ex_funct3_i,
  input  logic                   ex_mem_rd_i,
  input  logic                   ex_mem_wr_i,
  input  logic                   ex_reg_write_i,
  output logic [DMEM_AWIDTH-1:0] dmem_addr_o,
  output logic [3:0]             dmem_we_o,
  output logic [31:0]            dmem_din_o,
  input  logic [31:0]            dmem_dout_i,
  output logic [7:0]             uart_tx_data_o,
  output logic                   uart_tx_valid_o,
  input  logic                   uart_tx_ready_i,
  input  logic [7:0]             uart_rx_data_i,
  input  logic                   uart_rx_valid_i,
  output logic                   uart_rx_ready_o,
  output logic                   wb_en_o,
  output logic [4:0]             wb_addr_o,
  output logic [31:0]            wb_data_o
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC   = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  localparam logic [27:0] IO_STATUS = 28'h000_0000;
  localparam logic [27:0] IO_RXDATA = 28'h000_0004;
  localparam logic [27:0] IO_TXDATA = 28'h000_0008;
  localparam logic [27:0] IO_CYCLE  = 28'h000_0010;
  localparam logic [27:0] IO_INSTR  = 28'h000_0014;
  localparam logic [27:0] IO_CNTCLR = 28'h000_0018;

  // EX-side decode
  logic        mmio, ex_st, ex_ld, tx_wr, cnt_clr;
  logic [27:0] io_word;
  logic [3:0]  we;
  logic [31:0] din;

  // WB-side pipeline registers
  logic        valid_q, mmio_q, reg_write_q;
  logic [31:0] alu_q, pc_plus_q, mmio_rd_q, mmio_rd_d;
  logic [2:0]  funct3_q;
  logic [4:0]  wb_addr_q;
  wb_sel_e     wr_mux_q;

  // UART transmit holding register and counters
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] cyc_q, cyc_d, ins_q, ins_d;

  logic [31:0] load_word, load_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign mmio    = (ex_alu_result_i[31:28] == IO_NIBBLE);
  assign io_word = {ex_alu_result_i[27:2], 2'b00};
  assign ex_st   = ex_valid_i & ex_mem_wr_i;
  assign ex_ld   = ex_valid_i & ex_mem_rd_i;
  assign tx_wr   = ex_st & mmio & (io_word == IO_TXDATA);
  assign cnt_clr = ex_st & mmio & (io_word == IO_CNTCLR);

  assign dmem_addr_o     = ex_alu_result_i[DMEM_AWIDTH+1:2];
  assign uart_rx_ready_o = ex_ld & mmio & (io_word == IO_RXDATA);

  always_comb begin
    we  = '0;
    din = ex_mem_write_i;
    case (ex_funct3_i)
      3'b000: begin
        we  = 4'b0001 << ex_alu_result_i[1:0];
        din = {4{ex_mem_write_i[7:0]}};
      end
      3'b001: begin
        we  = ex_alu_result_i[1] ? 4'b1100 : 4'b0011;
        din = {2{ex_mem_write_i[15:0]}};
      end
      3'b010:  we = 4'b1111;
      default: we = '0;
    endcase
    if (!ex_st || mmio) we = '0;
  end

  assign dmem_we_o  = we;
  assign dmem_din_o = din;

  always_comb begin
    case (io_word)
      IO_STATUS: mmio_rd_d = {30'b0, uart_rx_valid_i, uart_tx_ready_i};
      IO_RXDATA: mmio_rd_d = {24'b0, uart_rx_data_i};
      IO_CYCLE:  mmio_rd_d = cyc_q;
      IO_INSTR:  mmio_rd_d = ins_q;
      default:   mmio_rd_d = '0;
    endcase
  end

  // A handshake in flight takes priority; a write arriving while pending is lost.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_valid_q) begin
      if (uart_tx_ready_i) tx_valid_d = 1'b0;
    end else if (tx_wr && uart_tx_ready_i) begin
      tx_valid_d = 1'b1;
      tx_data_d  = ex_mem_write_i[7:0];
    end
  end

  always_comb begin
    cyc_d = cnt_clr ? '0 : cyc_q + 32'd1;
    ins_d = cnt_clr ? '0 : ins_q + {31'b0, valid_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      mmio_q      <= 1'b0;
      reg_write_q <= 1'b0;
      alu_q       <= '0;
      pc_plus_q   <= '0;
      mmio_rd_q   <= '0;
      funct3_q    <= '0;
      wb_addr_q   <= '0;
      wr_mux_q    <= WB_ALU;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      cyc_q       <= '0;
      ins_q       <= '0;
    end else begin
      valid_q     <= ex_valid_i;
      mmio_q      <= mmio;
      reg_write_q <= ex_reg_write_i;
      alu_q       <= ex_alu_result_i;
      pc_plus_q   <= ex_pc_plus_i;
      mmio_rd_q   <= mmio_rd_d;
      funct3_q    <= ex_funct3_i;
      wb_addr_q   <= ex_wb_addr_i;
      wr_mux_q    <= wb_sel_e'(ex_wr_mux_i);
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      cyc_q       <= cyc_d;
      ins_q       <= ins_d;
    end
  end

  assign uart_tx_valid_o = tx_valid_q;
  assign uart_tx_data_o  = tx_data_q;

  always_comb begin
    load_word = mmio_q ? mmio_rd_q : dmem_dout_i;
    ld_byte   = load_word[{alu_q[1:0], 3'b000} +: 8];
    ld_half   = alu_q[1] ? load_word[31:16] : load_word[15:0];
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
      default: load_val = load_word;
    endcase
  end

  always_comb begin
    case (wr_mux_q)
      WB_LOAD: wb_data_o = load_val;
      WB_PC:   wb_data_o = pc_plus_q;
      default: wb_data_o = alu_q;
    endcase
  end

  assign wb_en_o   = valid_q & reg_write_q & (wb_addr_q != '0);
  assign wb_addr_o = wb_addr_q;

endmodule
